// File: rtl/fx_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fx_addsub_pipe
//  Purpose  : Fixed-point adder/subtractor for mixed Q-formats. Per-sample
//             add/subtract select, binary-point alignment, round-half-up or
//             floor quantisation, saturate or wrap on overflow, and a
//             valid-tagged pipeline of LATENCY stages.
//  Ports    : i_clk, i_rst (async, active high)
//             i_valid, i_sub, i_data_1 (Q(W1-F1).F1), i_data_2 (Q(W2-F2).F2)
//             i_clr_sticky  - clears o_ovf_sticky (a simultaneous set wins)
//             o_valid, o_data (Q(WO-FO).FO), o_ovf, o_ovf_sticky
//  Revision : 1.0 - initial release
// ============================================================================
module fx_addsub_pipe #(
    parameter int W1      = 12,
    parameter int F1      = 8,
    parameter int W2      = 12,
    parameter int F2      = 10,
    parameter int WO      = 12,
    parameter int FO      = 8,
    parameter int LATENCY = 3,
    parameter int SAT     = 1,
    parameter int RND     = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic          i_sub,
    input  logic [W1-1:0] i_data_1,
    input  logic [W2-1:0] i_data_2,
    input  logic          i_clr_sticky,
    output logic          o_valid,
    output logic [WO-1:0] o_data,
    output logic          o_ovf,
    output logic          o_ovf_sticky
);

    // Common internal format: FI fraction bits, II integer bits, plus two
    // guard bits so that the sum and the negation of the most negative
    // operand are always exact.
    localparam int c_fi = (F1 > F2) ? F1 : F2;
    localparam int c_i1 = W1 - F1;
    localparam int c_i2 = W2 - F2;
    localparam int c_ii = (c_i1 > c_i2) ? c_i1 : c_i2;
    localparam int c_ws = c_ii + c_fi + 2;

    // Quantised width: left shift grows the word, right shift keeps one
    // extra bit for the rounding carry before D bits are dropped.
    localparam int c_d  = (c_fi > FO) ? (c_fi - FO) : 0;
    localparam int c_wq = (FO >= c_fi) ? (c_ws + FO - c_fi) : (c_ws + 1 - c_d);
    // Comparison width: wide enough to hold both the quantised value and
    // the output bounds without losing sign.
    localparam int c_wc = ((c_wq > WO) ? c_wq : WO) + 1;

    localparam logic signed [c_wc-1:0] c_max = (c_wc'(1) <<< (WO - 1)) - c_wc'(1);
    localparam logic signed [c_wc-1:0] c_min = -(c_wc'(1) <<< (WO - 1));

    if (LATENCY < 2) begin : g_latency_check
        $error("fx_addsub_pipe: LATENCY must be at least 2");
    end

    // ------------------------------------------------------------------
    // Stage 1: align and add/subtract
    // ------------------------------------------------------------------
    logic signed [c_ws-1:0] w_a1;
    logic signed [c_ws-1:0] w_a2;
    logic signed [c_ws-1:0] w_op2;
    logic signed [c_ws-1:0] r_sum;
    logic                   r_v1;

    assign w_a1  = c_ws'($signed(i_data_1)) <<< (c_fi - F1);
    assign w_a2  = c_ws'($signed(i_data_2)) <<< (c_fi - F2);
    assign w_op2 = i_sub ? -w_a2 : w_a2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v1  <= 1'b0;
            r_sum <= '0;
        end else begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_sum <= w_a1 + w_op2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Quantise to FO fraction bits
    // ------------------------------------------------------------------
    logic signed [c_wq-1:0] w_q;

    if (FO >= c_fi) begin : g_quant_up
        assign w_q = c_wq'(r_sum) <<< (FO - c_fi);
    end else begin : g_quant_down
        localparam logic signed [c_ws:0] c_half =
            (RND != 0) ? ((c_ws + 1)'(1) <<< (c_d - 1)) : '0;
        logic signed [c_ws:0] w_ext;
        logic signed [c_ws:0] w_rnd;
        assign w_ext = (c_ws + 1)'(r_sum);
        assign w_rnd = w_ext + c_half;
        // Arithmetic shift floors; with the half-LSB added first this
        // becomes round-half-up.
        assign w_q   = c_wq'(w_rnd >>> c_d);
    end

    // ------------------------------------------------------------------
    // Range check and saturate / wrap
    // ------------------------------------------------------------------
    logic signed [c_wc-1:0] w_qc;
    logic                   w_ovf;
    logic [WO-1:0]          w_res;

    assign w_qc  = c_wc'(w_q);
    assign w_ovf = (w_qc > c_max) || (w_qc < c_min);

    always_comb begin
        w_res = w_qc[WO-1:0];
        if (w_ovf && (SAT != 0)) begin
            w_res = w_qc[c_wc-1] ? c_min[WO-1:0] : c_max[WO-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 result register followed by pure delay stages 3..LATENCY.
    // Data/ovf only load behind a valid so bubbles hold the last result.
    // ------------------------------------------------------------------
    logic          r_v [2:LATENCY];
    logic [WO-1:0] r_d [2:LATENCY];
    logic          r_o [2:LATENCY];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 2; k <= LATENCY; k++) begin
                r_v[k] <= 1'b0;
                r_d[k] <= '0;
                r_o[k] <= 1'b0;
            end
        end else begin
            r_v[2] <= r_v1;
            if (r_v1) begin
                r_d[2] <= w_res;
                r_o[2] <= w_ovf;
            end
            for (int k = 3; k <= LATENCY; k++) begin
                r_v[k] <= r_v[k-1];
                if (r_v[k-1]) begin
                    r_d[k] <= r_d[k-1];
                    r_o[k] <= r_o[k-1];
                end
            end
        end
    end

    assign o_valid = r_v[LATENCY];
    assign o_data  = r_d[LATENCY];
    assign o_ovf   = r_o[LATENCY];

    // Sticky overflow: a set on the same edge as a clear takes priority.
    logic r_sticky;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sticky <= 1'b0;
        end else if (o_valid && o_ovf) begin
            r_sticky <= 1'b1;
        end else if (i_clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign o_ovf_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fx_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fx_addsub_pipe
//  Purpose  : Self-checking bench for fx_addsub_pipe. Three instances share
//             the stimulus: (SAT=1,RND=1), (SAT=0,RND=1), (SAT=1,RND=0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fx_addsub_pipe;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        sub = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] d1 = '0;
    logic [11:0] d2 = '0;

    logic        ov [3];
    logic        oo [3];
    logic        os [3];
    logic [11:0] od [3];

    always #5 clk = ~clk;

    fx_addsub_pipe #(.LATENCY(L), .SAT(1), .RND(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sub(sub),
        .i_data_1(d1), .i_data_2(d2), .i_clr_sticky(clr),
        .o_valid(ov[0]), .o_data(od[0]), .o_ovf(oo[0]), .o_ovf_sticky(os[0])
    );
    fx_addsub_pipe #(.LATENCY(L), .SAT(0), .RND(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sub(sub),
        .i_data_1(d1), .i_data_2(d2), .i_clr_sticky(clr),
        .o_valid(ov[1]), .o_data(od[1]), .o_ovf(oo[1]), .o_ovf_sticky(os[1])
    );
    fx_addsub_pipe #(.LATENCY(L), .SAT(1), .RND(0)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sub(sub),
        .i_data_1(d1), .i_data_2(d2), .i_clr_sticky(clr),
        .o_valid(ov[2]), .o_data(od[2]), .o_ovf(oo[2]), .o_ovf_sticky(os[2])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h required %h at %0t", nm, c, got, exp, $time);
        end
    endtask

    // Reference arithmetic: work in units of 2^-10 (d1 has 8 fraction bits,
    // d2 has 10), then divide by 4 with floor to reach 8 fraction bits.
    function automatic logic [12:0] model(input bit s, input logic [11:0] a,
                                          input logic [11:0] b, input int sat, input int rnd);
        longint x, r, q;
        logic [11:0] lo;
        x  = longint'($signed(a)) * 4 + (s ? -longint'($signed(b)) : longint'($signed(b)));
        r  = x + ((rnd != 0) ? 2 : 0);
        q  = (r - (((r % 4) + 4) % 4)) / 4;
        lo = q[11:0];
        if (q > 2047)
            return {1'b1, (sat != 0) ? 12'h7FF : lo};
        else if (q < -2048)
            return {1'b1, (sat != 0) ? 12'h800 : lo};
        else
            return {1'b0, lo};
    endfunction

    // Latency model: a queue of in-flight samples L deep, with the last
    // delivered result held across bubbles.
    bit          p_v [L];
    bit          p_s [L];
    logic [11:0] p_a [L];
    logic [11:0] p_b [L];
    logic [12:0] m_res [3];
    bit          m_st [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                p_v[k] <= 1'b0;
                p_s[k] <= 1'b0;
                p_a[k] <= '0;
                p_b[k] <= '0;
            end
            for (int c = 0; c < 3; c++) begin
                m_res[c] <= '0;
                m_st[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                m_st[c] <= (p_v[L-1] && m_res[c][12]) || (m_st[c] && !clr);
                if (p_v[L-2])
                    m_res[c] <= model(p_s[L-2], p_a[L-2], p_b[L-2], (c != 1) ? 1 : 0, (c != 2) ? 1 : 0);
            end
            p_v[0] <= valid;
            p_s[0] <= sub;
            p_a[0] <= d1;
            p_b[0] <= d2;
            for (int k = 1; k < L; k++) begin
                p_v[k] <= p_v[k-1];
                p_s[k] <= p_s[k-1];
                p_a[k] <= p_a[k-1];
                p_b[k] <= p_b[k-1];
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            chk("valid",  c, 32'(ov[c]), 32'(p_v[L-1]));
            chk("data",   c, 32'(od[c]), 32'(m_res[c][11:0]));
            chk("ovf",    c, 32'(oo[c]), 32'(m_res[c][12]));
            chk("sticky", c, 32'(os[c]), 32'(m_st[c]));
        end
    end

    // One isolated sample, checked against hand-computed literals.
    task automatic run1(input bit s, input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] ea, input logic [11:0] eb, input logic [11:0] ec,
                        input bit eo, input string nm);
        int cnt;
        logic [11:0] e [3];
        e[0] = ea; e[1] = eb; e[2] = ec;
        @(posedge clk); #1;
        valid = 1'b1; sub = s; d1 = a; d2 = b;
        @(posedge clk); #1;
        valid = 1'b0; sub = ~s; d1 = 12'hABC; d2 = 12'h555;
        cnt = 0;
        while (cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (ov[0]) break;
        end
        chk({nm, "_lat"}, 0, 32'(cnt), 32'd3);
        for (int c = 0; c < 3; c++) begin
            chk({nm, "_data"}, c, 32'(od[c]), 32'(e[c]));
            chk({nm, "_ovf"},  c, 32'(oo[c]), 32'(eo));
        end
    endtask

    logic [11:0] sa [10] = '{12'h100, 12'h7FF, 12'h800, 12'h0FF, 12'h123,
                             12'hE00, 12'h001, 12'h400, 12'h2AB, 12'h0F0};
    logic [11:0] sb [10] = '{12'h200, 12'h800, 12'h001, 12'h7FF, 12'h456,
                             12'hC00, 12'h003, 12'h800, 12'h155, 12'h010};
    bit          ss [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("rst_valid", c, 32'(ov[c]), 32'd0);
            chk("rst_data",  c, 32'(od[c]), 32'd0);
            chk("rst_sticky", c, 32'(os[c]), 32'd0);
        end
        rst = 1'b0;

        run1(1'b1, 12'h100, 12'h200, 12'h080, 12'h080, 12'h080, 1'b0, "sub_basic");
        run1(1'b0, 12'h000, 12'h001, 12'h000, 12'h000, 12'h000, 1'b0, "rnd_1");
        run1(1'b0, 12'h000, 12'h002, 12'h001, 12'h001, 12'h000, 1'b0, "rnd_2");
        run1(1'b0, 12'h000, 12'h003, 12'h001, 12'h001, 12'h000, 1'b0, "rnd_3");
        run1(1'b0, 12'h000, 12'hFFE, 12'h000, 12'h000, 12'hFFF, 1'b0, "rnd_m2");
        run1(1'b1, 12'h7FF, 12'h800, 12'h7FF, 12'h9FF, 12'h7FF, 1'b1, "ovf");
        @(negedge clk);
        for (int c = 0; c < 3; c++) chk("sticky_set", c, 32'(os[c]), 32'd1);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) chk("sticky_clr", c, 32'(os[c]), 32'd0);
        run1(1'b1, 12'h000, 12'h800, 12'h200, 12'h200, 12'h200, 1'b0, "mostneg");

        // Streaming: 8 back-to-back, 3-cycle gap with junk inputs, then 2.
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin
                repeat (3) begin
                    @(posedge clk); #1;
                    valid = 1'b0; sub = 1'b1; d1 = 12'h5A5; d2 = 12'h3C3;
                end
            end
            @(posedge clk); #1;
            valid = 1'b1; sub = ss[i]; d1 = sa[i]; d2 = sb[i];
        end
        @(posedge clk); #1 valid = 1'b0;
        repeat (6) @(posedge clk);

        // Reset with two samples in flight.
        #1 valid = 1'b1; sub = 1'b0; d1 = 12'h100; d2 = 12'h100;
        @(posedge clk); #1 d1 = 12'h200;
        @(posedge clk); #1 valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("midrst_valid", c, 32'(ov[c]), 32'd0);
            chk("midrst_data",  c, 32'(od[c]), 32'd0);
            chk("midrst_ovf",   c, 32'(oo[c]), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov[0] || ov[1] || ov[2]) cnt++;
        end
        chk("post_rst_novalid", 0, 32'(cnt), 32'd0);

        // Clear coincident with a new overflow: set wins.
        @(posedge clk); #1;
        valid = 1'b1; sub = 1'b1; d1 = 12'h7FF; d2 = 12'h800;
        @(posedge clk); #1 valid = 1'b0;
        cnt = 0;
        while (cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (ov[0]) break;
        end
        chk("clr_ovf_lat", 0, 32'(cnt), 32'd3);
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) chk("clr_vs_set", c, 32'(os[c]), 32'd1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
